// File: rtl/mem_byte_ctrl.sv
// mem_byte_ctrl: serialises byte/half/word loads and stores onto an 8-bit RAM port with 1-cycle read latency.
// Define MEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of splitting them bytewise.
module mem_byte_ctrl #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [7:0]            ram_din_o,
  output logic                  ram_we_o,
  input  logic [7:0]            ram_dout_i
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t                state, state_next;
  logic                  we_q, uns_q, err_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, rdata_q, load_data;
  logic [2:0]            cnt, nbytes;
  logic [1:0]            cap_idx;
  logic                  accept, acc_err;

  always_comb begin
    case (size_q)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  always_comb begin
    acc_err = (req_size_i == 2'b11);
`ifdef MEM_MISALIGN_TRAP_EN
    if (req_size_i == 2'b01 && req_addr_i[0]) acc_err = 1'b1;
    if (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00) acc_err = 1'b1;
`endif
  end

  always_comb begin
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & rdata_q[7]}}, rdata_q[7:0]};
      2'b01:   load_data = {{16{~uns_q & rdata_q[15]}}, rdata_q[15:0]};
      default: load_data = rdata_q;
    endcase
  end

  // Read data lags the driven address by one cycle, so READ runs one cycle past the last address.
  assign cap_idx = cnt[1:0] - 2'd1;

  always_comb begin
    state_next  = state;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    ram_addr_o  = '0;
    ram_din_o   = '0;
    ram_we_o    = 1'b0;
    case (state)
      IDLE: req_ready_o = 1'b1;
      WRITE: begin
        ram_we_o   = 1'b1;
        ram_addr_o = addr_q + ADDR_WIDTH'(cnt);
        ram_din_o  = wdata_q[{cnt[1:0], 3'b000} +: 8];
        if (cnt == nbytes - 3'd1) state_next = RESP;
      end
      READ: begin
        if (!err_q) ram_addr_o = addr_q + ADDR_WIDTH'(cnt);
        if (err_q || cnt == nbytes) state_next = RESP;
      end
      RESP: begin
        req_ready_o = 1'b1;
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        rsp_rdata_o = (err_q || we_q) ? '0 : load_data;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
    accept = req_valid_i & req_ready_o;
    // Rejected requests pass through READ for one cycle with the RAM port idle.
    if (accept) state_next = (acc_err || !req_we_i) ? READ : WRITE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        we_q    <= req_we_i;
        uns_q   <= req_unsigned_i;
        size_q  <= req_size_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        err_q   <= acc_err;
        cnt     <= '0;
        rdata_q <= '0;
      end else if (state == WRITE || state == READ) begin
        cnt <= cnt + 3'd1;
        if (state == READ && cnt != 3'd0) rdata_q[{cap_idx, 3'b000} +: 8] <= ram_dout_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_byte_ctrl.sv
// Scoreboard bench for mem_byte_ctrl: directed scenarios then random traffic against a byte-array reference model.
module tb_mem_byte_ctrl;
  localparam int unsigned AW = 12;
  localparam int MEMSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_we = 1'b0, req_uns = 1'b0;
  logic [1:0]    req_size = '0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          req_ready, rsp_valid, rsp_err, ram_we;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din, ram_dout;

  mem_byte_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .ram_addr_o(ram_addr),
    .ram_din_o(ram_din), .ram_we_o(ram_we), .ram_dout_i(ram_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ram     [MEMSZ];
  logic [7:0] ref_mem [MEMSZ];

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0, errors = 0;
  int   we_count = 0, exp_writes = 0;
  bit   armed = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int nbytes(logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_err(logic [1:0] s, logic [AW-1:0] a);
    if (s == 2'd3) return 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
    if (s == 2'd1 && (int'(a) % 2) != 0) return 1'b1;
    if (s == 2'd2 && (int'(a) % 4) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_rdata", rsp_rdata, mon_e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
          check("rsp_cycle", cyc, mon_e.cyc);
        end
      end else begin
        check("idle_rdata", rsp_rdata, 32'h0);
        check("idle_err", 32'(rsp_err), 32'h0);
      end
      if (req_ready && !rsp_valid) check("idle_ram_port", 32'({ram_we, ram_addr, ram_din}), 32'h0);
      if (ram_we) we_count++;
    end
  end

  task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                       input logic [AW-1:0] addr, input logic [31:0] wdata,
                       input bit keep, input bit modeled, output int c0);
    exp_t        e;
    int          n;
    bit          ok;
    logic [31:0] val;
    ok = 1'b0;
    c0 = -1;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns;
    req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (req_ready) begin
        @(posedge clk);
        #1;
        c0 = cyc;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!keep || !ok) req_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
    end else if (modeled) begin
      n = nbytes(size);
      e.err = is_err(size, addr);
      e.rdata = '0;
      if (e.err) begin
        e.cyc = c0 + 1;
      end else if (we) begin
        e.cyc = c0 + n;
        for (int k = 0; k < n; k++) ref_mem[(int'(addr) + k) % MEMSZ] = wdata[8*k +: 8];
        exp_writes += n;
      end else begin
        e.cyc = c0 + n + 1;
        val = '0;
        for (int k = 0; k < n; k++) val = val | (32'(ref_mem[(int'(addr) + k) % MEMSZ]) << (8*k));
        if (n < 4 && !uns && val[8*n-1]) for (int b = 8*n; b < 32; b++) val[b] = 1'b1;
        e.rdata = val;
      end
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int            c0, c0a, c0b;
    logic [7:0]    v;
    logic [AW-1:0] a;
    bit            keep;
    for (int i = 0; i < MEMSZ; i++) begin
      v = 8'($urandom);
      ram[i] <= v;
      ref_mem[i] = v;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    armed = 1'b1;
    check("reset_ready", 32'(req_ready), 32'h1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_ram_port", 32'({ram_we, ram_addr, ram_din}), 32'h0);

    issue(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 1'b0, 1'b1, c0);
    issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 1'b0, 1'b1, c0);
    issue(1'b0, 2'd0, 1'b0, 12'h013, 32'h0, 1'b0, 1'b1, c0);
    issue(1'b0, 2'd0, 1'b1, 12'h013, 32'h0, 1'b0, 1'b1, c0);
    issue(1'b0, 2'd1, 1'b0, 12'h012, 32'h0, 1'b0, 1'b1, c0);
    issue(1'b0, 2'd1, 1'b1, 12'h012, 32'h0, 1'b0, 1'b1, c0);
    drain();
    check("word_store_b0", 32'(ram[12'h010]), 32'hEF);
    check("word_store_b1", 32'(ram[12'h011]), 32'hBE);
    check("word_store_b2", 32'(ram[12'h012]), 32'hAD);
    check("word_store_b3", 32'(ram[12'h013]), 32'hDE);

    v = ram[12'hFFE];
    issue(1'b1, 2'd2, 1'b0, 12'hFFE, 32'h11223344, 1'b0, 1'b1, c0);
    drain();
`ifdef MEM_MISALIGN_TRAP_EN
    check("trap_no_write", 32'(ram[12'hFFE]), 32'(v));
`else
    check("wrap_b0", 32'(ram[12'hFFE]), 32'h44);
    check("wrap_b1", 32'(ram[12'hFFF]), 32'h33);
    check("wrap_b2", 32'(ram[12'h000]), 32'h22);
    check("wrap_b3", 32'(ram[12'h001]), 32'h11);
`endif

    issue(1'b1, 2'd3, 1'b0, 12'h100, 32'hCAFEF00D, 1'b0, 1'b1, c0);
    drain();

    issue(1'b1, 2'd2, 1'b0, 12'h020, 32'hAABBCCDD, 1'b0, 1'b0, c0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_ready", 32'(req_ready), 32'h1);
    check("abort_no_rsp", 32'(rsp_valid), 32'h0);
    ref_mem[12'h020] = 8'hDD;
    ref_mem[12'h021] = 8'hCC;
    exp_writes += 2;
    repeat (2) @(negedge clk);
    check("abort_b0", 32'(ram[12'h020]), 32'hDD);
    check("abort_b1", 32'(ram[12'h021]), 32'hCC);
    check("abort_b2", 32'(ram[12'h022]), 32'(ref_mem[12'h022]));

    issue(1'b1, 2'd2, 1'b0, 12'h040, $urandom, 1'b1, 1'b1, c0a);
    issue(1'b1, 2'd2, 1'b0, 12'h044, $urandom, 1'b0, 1'b1, c0b);
    check("b2b_accept", c0b, c0a + 5);
    drain();

    for (int t = 0; t < 300; t++) begin
      a = ($urandom % 4 == 0) ? AW'(12'hFFC + 12'($urandom % 4)) : AW'($urandom);
      keep = ($urandom % 3 == 0);
      issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, keep, 1'b1, c0);
      if (!keep) repeat ($urandom % 3) @(negedge clk);
    end
    req_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("queue_empty", sb.size(), 32'h0);
    check("write_count", we_count, exp_writes);
    for (int i = 0; i < MEMSZ; i++) check("mem_final", 32'(ram[i]), 32'(ref_mem[i]));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got simulation still running expected completion");
    $fatal(1, "timeout");
  end

endmodule
